// File: rtl/cont_bcd_n_if.sv
// Bus bundle for the cont_bcd_n multi-digit BCD counter.
// The control, load, count and cascade signals travel together; Clk and Rst stay plain ports.
`timescale 1ns/1ps
interface cont_bcd_n_if #(
    parameter int unsigned NDIG = 4
) ();
    localparam int unsigned W = 4 * NDIG;

    logic         Load;
    logic         Enable;
    logic         Up;
    logic [W-1:0] Valor;
    logic [W-1:0] Cuenta;
    logic         TCO;
    logic         CEO;
    logic         Wrap;

    modport master (
        output Load, Enable, Up, Valor,
        input  Cuenta, TCO, CEO, Wrap
    );

    modport slave (
        input  Load, Enable, Up, Valor,
        output Cuenta, TCO, CEO, Wrap
    );
endinterface

// File: rtl/cont_bcd_n.sv
// NDIG-digit BCD counter with clamped parallel load, cascade enable and a registered wrap pulse.
// Define CONT_BCD_UPDOWN_EN to add down counting selected by Up.
`timescale 1ns/1ps
module cont_bcd_n #(
    parameter int unsigned NDIG = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    cont_bcd_n_if.slave bus
);
    localparam int unsigned W = 4 * NDIG;

    logic [W-1:0] cuenta_q, cuenta_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] inc_val;
    logic [W-1:0] load_val;
    logic         all9;
    logic         tco;

    // Ripple-carry increment: a digit steps only while every lower digit is 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (carry) begin
                r[4*k +: 4] = (v[4*k +: 4] == 4'd9) ? 4'd0 : v[4*k +: 4] + 4'd1;
            end
            carry = carry & (v[4*k +: 4] == 4'd9);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign inc_val  = bcd_inc(cuenta_q);
    assign load_val = bcd_clamp(bus.Valor);

    always_comb begin
        all9 = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            all9 = all9 & (cuenta_q[4*k +: 4] == 4'd9);
        end
    end

`ifdef CONT_BCD_UPDOWN_EN
    logic [W-1:0] dec_val;
    logic         all0;
    logic         down;

    // Ripple-borrow decrement: a digit steps only while every lower digit is 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (borrow) begin
                r[4*k +: 4] = (v[4*k +: 4] == 4'd0) ? 4'd9 : v[4*k +: 4] - 4'd1;
            end
            borrow = borrow & (v[4*k +: 4] == 4'd0);
        end
        return r;
    endfunction

    assign dec_val = bcd_dec(cuenta_q);
    assign all0    = (cuenta_q == W'(0));
    assign down    = ~bus.Up;
    assign tco     = down ? all0 : all9;
`else
    assign tco     = all9;
`endif

    // Rst > Load > Enable > hold; Wrap marks an enabled step taken from terminal count.
    always_comb begin
        cuenta_d = cuenta_q;
        wrap_d   = 1'b0;
        if (Rst) begin
            cuenta_d = W'(0);
            wrap_d   = 1'b0;
        end else if (bus.Load) begin
            cuenta_d = load_val;
            wrap_d   = 1'b0;
        end else if (bus.Enable) begin
`ifdef CONT_BCD_UPDOWN_EN
            cuenta_d = down ? dec_val : inc_val;
`else
            cuenta_d = inc_val;
`endif
            wrap_d   = tco;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cuenta_q <= W'(0);
            wrap_q   <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.Cuenta = cuenta_q;
    assign bus.Wrap   = wrap_q;
    assign bus.TCO    = tco;
    assign bus.CEO    = tco & bus.Enable & ~bus.Load & ~Rst;
endmodule

// File: doc/cont_bcd_n.md
# cont_bcd_n

Parametrised multi-digit BCD counter with parallel load, count enable, cascade outputs and a registered wrap pulse. It generalises the single-digit 0–9 counter to NDIG decimal digits counting 0 to 10^NDIG−1. An optional compile-time up/down mode is available. It feeds display multiplexers and timebase dividers, and can be chained with further instances through CEO.

## Interface
- NDIG, default 4: number of BCD digits; legal range 1..8.
- Clk  input  1  clock; all state changes on its rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Load  input  1  parallel load of Valor.
- Enable  input  1  count enable.
- Up  input  1  direction, 1 = up, 0 = down; only meaningful with CONT_BCD_UPDOWN_EN.
- Valor  input  4*NDIG  load value, digit k in bits [4k+3:4k], digit 0 least significant.
- Cuenta  output  4*NDIG  current count, same digit packing as Valor.
- TCO  output  1  terminal count, combinational.
- CEO  output  1  cascade enable, combinational: TCO & Enable & ~Load & ~Rst.
- Wrap  output  1  registered one-cycle pulse, asserted the cycle after the counter wraps.

## Operation
- Priority per edge: Rst > Load > Enable > hold.
- Rst: all digits 0; Wrap 0.
- Load: each digit takes its Valor nibble.
  - A nibble >9 is clamped to 9, per digit and independently.
  - Wrap is 0 on the following cycle.
- Enable, counting up:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k−1 are all 9; a digit at 9 that increments becomes 0.
  - All digits at 9 roll over to all 0.
- Enable, counting down (macro only):
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k−1 are all 0; a digit at 0 that decrements becomes 9.
  - All digits at 0 roll over to all 9.
- Digit values stay in 0..9 in every reachable state after reset or load.
- TCO:
  - Up mode: 1 when every digit = 9.
  - Down mode: 1 when every digit = 0.
  - TCO is independent of Enable.
- Wrap: registered; 1 for exactly one cycle after any edge on which Enable was active (no Rst/Load) and TCO was 1.
- Changing Up while enabled takes effect on the next edge; no extra state is involved.

## Timing
- Reset values: Cuenta = 0, Wrap = 0. TCO = 1 only if the direction is down (macro on, Up = 0), otherwise 0.
- Count latency: one cycle from Enable sampled high to the updated Cuenta.
- Load latency: one cycle from Load sampled high to Cuenta = clamped Valor.
- TCO and CEO follow Cuenta, Up, Enable and Load combinationally within the same cycle.
- Wrap lags the rollover edge by zero cycles: it is high during the cycle in which Cuenta shows the rolled-over value.
- Simultaneous Load and Enable: Load wins, no count, no Wrap.
- Rst mid-count or during Load: Cuenta = 0 on that edge, Wrap cleared.
- Cascading: the next instance's Enable = this CEO, giving a single-cycle carry with no added latency.

## Configuration
- CONT_BCD_UPDOWN_EN defined:
  - Up selects direction.
  - Borrow chain, down rollover and down-mode TCO are implemented.
- CONT_BCD_UPDOWN_EN undefined:
  - Up is ignored; counting is always up; TCO means all digits = 9.
  - No decrement logic is synthesised; the port list is unchanged.

## Test plan
- NDIG=3, Rst, then Enable=1 for 1000 cycles → Cuenta steps 000…999. TCO=1 only at 999. Wrap=1 for exactly one cycle, when Cuenta returns to 000.
- Load Valor=0x4F9 (digit 1 = F) → Cuenta = 0x499 the next cycle. Enable one cycle → 0x500, Wrap stays 0.
- Load=1 and Enable=1 together with Valor=0x123 → Cuenta = 0x123, no increment. Then Rst asserted with Enable=1 → Cuenta = 0x000.
- Macro on, Up=0, load 0x100, enable 2 cycles → 0x099, 0x098. Load 0x000 → TCO=1; enable 1 cycle → 0x999, Wrap=1.
- Two NDIG=2 instances chained via CEO→Enable from 0x9999 → both show 00 on the same edge; the upper instance's Wrap pulses.
- Macro off, Up=0, Enable from 0x998 → counts up to 0x999 then 0x000; Up has no effect.
